svo_tmds_rx: RTL and testbench
==============================

Name: svo_tmds_rx

Overview:
- TMDS receive-side channel aligner and decoder: the inverse of the per-channel TMDS encode plus 10:1 serialisation path.
- Takes one 10-bit parallel word per pixel clock from a 1:10 deserialiser whose word boundary is arbitrary.
- Finds the symbol boundary by hunting for TMDS control tokens, then decodes 10b symbols to de/ctrl/8-bit data.
- Sits in the pixel clock domain of a future HDMI-input path; one instance per TMDS channel.

Parameters:
CTRL_RUN, 16, consecutive control tokens required at one offset to declare lock
TIMEOUT, 4096, cycles without any control token before the current offset is abandoned
TIMER_BITS, 13, width of timeout counter; must hold TIMEOUT

Ports:
clk  in  1  pixel clock
resetn  in  1  asynchronous active-low reset
din  in  10  raw deserialised word; din[0] is the earliest bit on the wire
offset  out  4  current bit-slip offset, 0..9
locked  out  1  symbol alignment established
de  out  1  data enable (decoded symbol was not a control token)
ctrl  out  2  decoded control bits {c1,c0}; valid when de=0
dout  out  8  decoded pixel byte; valid when de=1
relock_count  out  8  saturating count of lock losses since reset

Behaviour:
- Reset: asynchronous on resetn low. offset=0, locked=0, de=0, ctrl=0, dout=0, relock_count=0, FSM=SEARCH, timer=0, run=0, din_q=0.
- Alignment window:
  - din_q registers din every cycle.
  - cat[19:0]={din, din_q}; sym=cat[offset+9:offset], combinational.
  - offset 0 passes din_q unchanged.
- Tokens, q[9:0] written MSB first: ctrl 00=1101010100, 01=0010101011, 10=0101010100, 11=1010101011. is_tok = sym equals any of the four.
- Decode, combinational on sym:
  - d = q[9] ? ~q[7:0] : q[7:0].
  - dout[0]=d[0].
  - dout[i] = q[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]), for i=1..7.
- Output register: latency 2 clocks from din to outputs (din->din_q, then sym->outputs).
  - If locked: de=!is_tok; ctrl=token code when is_tok, else hold the previous ctrl; dout=decoded value when !is_tok, else 0.
  - If not locked: de=0, ctrl=0, dout=0.
- FSM:
  - SEARCH:
    - timer increments each cycle.
    - is_tok -> VERIFY with run=1, timer=0.
    - timer==TIMEOUT-1 -> offset=(offset==9)?0:offset+1, timer=0, stay.
  - VERIFY:
    - is_tok -> run+1, timer=0.
    - run reaches CTRL_RUN -> LOCKED, locked=1 on the next cycle.
    - !is_tok before that -> SEARCH with run=0; offset unchanged; timer continues from 0.
  - LOCKED:
    - timer=0 on every token, otherwise increments.
    - timer==TIMEOUT-1 -> SEARCH, locked=0, offset advanced as in SEARCH, relock_count+1 saturating at 255.
- Offset change takes effect on the next cycle's window; one spurious symbol after a change is tolerated.
- Simultaneous events:
  - Timeout and token in the same cycle: the token wins and timer clears.
  - Offset wraps 9->0.
- Reset mid-lock: all state returns to reset values immediately; relock_count clears.

Decomposition:
- Package svo_tmds_pkg holds:
  - the four token constants;
  - the FSM state encoding (SEARCH/VERIFY/LOCKED);
  - the token-to-ctrl mapping function.
- Sub-module svo_tmds_symdec: purely combinational 10b->{is_tok, ctrl, data}. Reusable by a future HDMI-input top and by benches.
- Window mux, timers and FSM live in svo_tmds_rx.

Test Plan:
1. Reset: assert resetn=0 mid-stream -> all outputs 0 immediately; after release offset=0, locked=0.
2. Aligned lock: encoder-model stream at offset 0, 40 tokens ctrl=2'b10 then pixels 0x00,0x55,0xAA,0xFF:
   - locked=1 within CTRL_RUN+2 cycles of the first token;
   - de=1 and dout=0x00,0x55,0xAA,0xFF, each 2 cycles after input.
3. Misaligned: stream delayed 3 bits -> offset steps 0,1,2,3 at TIMEOUT intervals, then locks at 3; decoded bytes match the encoder input.
4. Broken run: 10 tokens, 1 data symbol, then 20 tokens -> no lock after the first run, offset stays 0, locked asserts during the second run.
5. Loss of lock: after lock, send only data symbols for TIMEOUT cycles -> locked=0, offset=1, relock_count=1; restore tokens at offset 1 -> relock.
6. Wrap and saturation:
   - 7-bit delay starting from offset 9 (forced via repeated timeouts) -> offset wraps to 0 and re-hunts;
   - 300 forced lock losses -> relock_count=255.

Source files
------------

// File: rtl/svo_tmds_pkg.sv
// Shared definitions for the TMDS receive channel: control tokens, aligner
// FSM states and the token-to-control-code lookup.
package svo_tmds_pkg;

    localparam logic [9:0] TOK_C00 = 10'b1101010100;
    localparam logic [9:0] TOK_C01 = 10'b0010101011;
    localparam logic [9:0] TOK_C10 = 10'b0101010100;
    localparam logic [9:0] TOK_C11 = 10'b1010101011;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_VERIFY,
        ST_LOCKED
    } state_e;

    typedef struct packed {
        logic       hit;
        logic [1:0] code;
    } tok_t;

    function automatic tok_t tok_decode(input logic [9:0] q);
        tok_t t;
        t.hit  = 1'b1;
        t.code = '0;
        case (q)
            TOK_C00: t.code = 2'b00;
            TOK_C01: t.code = 2'b01;
            TOK_C10: t.code = 2'b10;
            TOK_C11: t.code = 2'b11;
            default: t.hit  = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/svo_tmds_symdec.sv
// Combinational TMDS 10b symbol decoder: control-token detection plus
// 8-bit data recovery (optional inversion, then XOR/XNOR chain undo).
module svo_tmds_symdec
    import svo_tmds_pkg::*;
(
    input  logic [9:0] sym,
    output logic       is_tok,
    output logic [1:0] ctrl,
    output logic [7:0] data
);

    tok_t       tok;
    logic [7:0] d;

    always_comb begin
        tok    = tok_decode(sym);
        is_tok = tok.hit;
        ctrl   = tok.code;
        d      = sym[9] ? ~sym[7:0] : sym[7:0];
        data   = {(sym[8] ? (d[7:1] ^ d[6:0]) : ~(d[7:1] ^ d[6:0])), d[0]};
    end

endmodule

// File: rtl/svo_tmds_rx.sv
// TMDS channel receiver: bit-slip window over two deserialised words, token
// hunting aligner, and registered decode of the aligned symbol stream.
module svo_tmds_rx
    import svo_tmds_pkg::*;
#(
    parameter int unsigned CTRL_RUN   = 16,
    parameter int unsigned TIMEOUT    = 4096,
    parameter int unsigned TIMER_BITS = 13
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] din,
    output logic [3:0] offset,
    output logic       locked,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] dout,
    output logic [7:0] relock_count
);

    localparam int unsigned           RUN_BITS = $clog2(CTRL_RUN + 1);
    localparam logic [RUN_BITS-1:0]   RUN_LAST = RUN_BITS'(CTRL_RUN - 1);
    localparam logic [TIMER_BITS-1:0] TMO_LAST = TIMER_BITS'(TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [9:0]            din_q;
    logic [3:0]            offset_q, offset_d, offset_next;
    logic [TIMER_BITS-1:0] timer_q, timer_d;
    logic [RUN_BITS-1:0]   run_q, run_d;
    logic                  locked_q, locked_d;
    logic                  de_q, de_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [7:0]            dout_q, dout_d;
    logic [7:0]            relock_q, relock_d;

    logic [19:0] cat;
    logic [9:0]  sym;
    logic        is_tok;
    logic [1:0]  tok_ctrl;
    logic [7:0]  data;
    logic        timeout;

    // din_q holds the older word, so offset 0 selects it untouched.
    assign cat = {din, din_q};
    assign sym = 10'(cat >> offset_q);

    svo_tmds_symdec u_symdec (
        .sym    (sym),
        .is_tok (is_tok),
        .ctrl   (tok_ctrl),
        .data   (data)
    );

    assign timeout     = (timer_q == TMO_LAST);
    assign offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        offset_d = offset_q;
        timer_d  = timer_q + 1'b1;
        run_d    = run_q;
        locked_d = locked_q;
        relock_d = relock_q;
        case (state_q)
            ST_SEARCH: begin
                if (is_tok) begin
                    state_d = ST_VERIFY;
                    run_d   = RUN_BITS'(1);
                    timer_d = '0;
                end else if (timeout) begin
                    offset_d = offset_next;
                    timer_d  = '0;
                end
            end
            ST_VERIFY: begin
                timer_d = '0;
                if (is_tok) begin
                    run_d = run_q + 1'b1;
                    if (run_q == RUN_LAST) begin
                        state_d  = ST_LOCKED;
                        locked_d = 1'b1;
                    end
                end else begin
                    state_d = ST_SEARCH;
                    run_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (is_tok) begin
                    timer_d = '0;
                end else if (timeout) begin
                    state_d  = ST_SEARCH;
                    locked_d = 1'b0;
                    offset_d = offset_next;
                    timer_d  = '0;
                    run_d    = '0;
                    relock_d = (relock_q == 8'hFF) ? relock_q : relock_q + 8'd1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        de_d   = 1'b0;
        ctrl_d = '0;
        dout_d = '0;
        if (locked_q) begin
            de_d   = !is_tok;
            ctrl_d = is_tok ? tok_ctrl : ctrl_q;
            dout_d = is_tok ? 8'h00 : data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_SEARCH;
            din_q    <= '0;
            offset_q <= '0;
            timer_q  <= '0;
            run_q    <= '0;
            locked_q <= 1'b0;
            de_q     <= 1'b0;
            ctrl_q   <= '0;
            dout_q   <= '0;
            relock_q <= '0;
        end else begin
            state_q  <= state_d;
            din_q    <= din;
            offset_q <= offset_d;
            timer_q  <= timer_d;
            run_q    <= run_d;
            locked_q <= locked_d;
            de_q     <= de_d;
            ctrl_q   <= ctrl_d;
            dout_q   <= dout_d;
            relock_q <= relock_d;
        end
    end

    assign offset       = offset_q;
    assign locked       = locked_q;
    assign de           = de_q;
    assign ctrl         = ctrl_q;
    assign dout         = dout_q;
    assign relock_count = relock_q;

endmodule

// File: tb/tb_svo_tmds_rx.sv
// Directed bench for svo_tmds_rx: a local TMDS encoder and bit-delay model
// feed the receiver; decoded outputs are compared one symbol behind the input.
module tb_svo_tmds_rx;

    localparam int unsigned T   = 64;
    localparam int unsigned RUN = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic [9:0] din;
    logic [3:0] offset;
    logic       locked;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] dout;
    logic [7:0] relock_count;

    svo_tmds_rx #(
        .CTRL_RUN   (RUN),
        .TIMEOUT    (T),
        .TIMER_BITS (13)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .din          (din),
        .offset       (offset),
        .locked       (locked),
        .de           (de),
        .ctrl         (ctrl),
        .dout         (dout),
        .relock_count (relock_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [9:0]  prev_sym;
    int unsigned dly;
    logic        chk_en;
    logic        pend_valid;
    logic        pend_de;
    logic [7:0]  pend_dout;
    logic [1:0]  pend_ctrl;
    logic [1:0]  last_ctrl;
    logic [7:0]  px [6];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] tok(input logic [1:0] c);
        case (c)
            2'b00:   return 10'b1101010100;
            2'b01:   return 10'b0010101011;
            2'b10:   return 10'b0101010100;
            default: return 10'b1010101011;
        endcase
    endfunction

    function automatic logic [9:0] enc(input logic [7:0] d, input logic inv);
        logic       xn;
        logic [7:0] qm;
        xn    = ($countones(d) > 4) || ($countones(d) == 4 && !d[0]);
        qm[0] = d[0];
        for (int i = 1; i < 8; i++)
            qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        return {inv, ~xn, (inv ? ~qm : qm)};
    endfunction

    // Wire stream delayed by dly bits: low dly bits come from the previous symbol.
    task automatic drive(input logic [9:0] s);
        logic [19:0] cat;
        cat      = {s, prev_sym};
        din      = 10'(cat >> (10 - dly));
        prev_sym = s;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] s, input logic is_d, input logic [7:0] b, input logic [1:0] c);
        drive(s);
        if (chk_en && pend_valid) begin
            check("de", de, pend_de);
            check("dout", dout, pend_dout);
            check("ctrl", ctrl, pend_ctrl);
        end
        pend_valid = 1'b1;
        pend_de    = is_d;
        pend_dout  = is_d ? b : 8'h00;
        if (!is_d) last_ctrl = c;
        pend_ctrl  = last_ctrl;
    endtask

    task automatic send_tok(input logic [1:0] c);
        send(tok(c), 1'b0, 8'h00, c);
    endtask

    task automatic send_px(input logic [7:0] b, input logic inv);
        send(enc(b, inv), 1'b1, b, 2'b00);
    endtask

    task automatic send_pixels();
        for (int i = 0; i < 6; i++) send_px(px[i], 1'(i % 2));
        send_tok(2'b10);
    endtask

    task automatic do_reset();
        resetn     = 1'b0;
        din        = '0;
        prev_sym   = '0;
        dly        = 0;
        chk_en     = 1'b0;
        pend_valid = 1'b0;
        last_ctrl  = 2'b00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_offset"}, offset, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_de"}, de, 0);
        check({tag, "_ctrl"}, ctrl, 0);
        check({tag, "_dout"}, dout, 0);
        check({tag, "_relock"}, relock_count, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned first;
        px = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h3C, 8'h81};

        // reset state
        resetn = 1'b1;
        din    = '0;
        #2 resetn = 1'b0;
        #1 check_all_zero("rst");
        do_reset();
        check("rst_rel_offset", offset, 0);
        check("rst_rel_locked", locked, 0);

        // aligned lock, pixel decode, reset mid-stream
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            send_tok(2'b10);
            if (locked && first == 0) first = i;
            if (i == 20) chk_en = 1'b1;
        end
        check("lock_lat", (first >= RUN + 1 && first <= RUN + 2), 1);
        send_pixels();
        send_px(8'hFF, 1'b0);
        send_tok(2'b10);
        check("pre_rst_dout", dout, 8'hFF);
        #2 resetn = 1'b0;
        #1 check_all_zero("mid_rst");
        do_reset();

        // stream delayed 3 bits: offset steps every T cycles, then locks at 3
        dly = 3;
        for (int i = 1; i <= 3 * T; i++) begin
            send_tok(2'b10);
            if (i == T - 1) check("mis_off0", offset, 0);
            if (i == T)     check("mis_off1", offset, 1);
            if (i == 2 * T) check("mis_off2", offset, 2);
            if (i == 3 * T) check("mis_off3", offset, 3);
        end
        for (int i = 0; i < RUN + 2; i++) send_tok(2'b10);
        check("mis_locked", locked, 1);
        check("mis_offset", offset, 3);
        chk_en = 1'b1;
        send_pixels();
        do_reset();

        // broken run: no lock from the first run
        for (int i = 0; i < 10; i++) send_tok(2'b01);
        send_px(8'h55, 1'b0);
        check("brk_locked0", locked, 0);
        for (int j = 1; j <= 20; j++) begin
            send_tok(2'b01);
            if (j == 15) begin
                check("brk_locked1", locked, 0);
                check("brk_offset", offset, 0);
            end
        end
        check("brk_locked2", locked, 1);
        do_reset();

        // loss of lock and relock at the next offset
        for (int i = 0; i < 20; i++) send_tok(2'b11);
        check("los_locked0", locked, 1);
        for (int m = 1; m <= T + 2; m++) begin
            send_px(8'(m * 37), 1'(m % 2));
            if (m == T - 2) check("los_hold", locked, 1);
        end
        check("los_locked1", locked, 0);
        check("los_offset", offset, 1);
        check("los_relock", relock_count, 1);
        dly = 1;
        for (int i = 0; i < 20; i++) send_tok(2'b00);
        check("rel_locked", locked, 1);
        check("rel_offset", offset, 1);
        check("rel_relock", relock_count, 1);
        #2 resetn = 1'b0;
        #1 check("rl_rst_relock", relock_count, 0);
        check("rl_rst_locked", locked, 0);
        do_reset();

        // force offset 9 with garbage, then a 7-bit delayed stream wraps and relocks
        for (int i = 1; i <= 9 * T; i++) begin
            drive(10'h000);
            if (i == 9 * T - 1) check("wrap_off8", offset, 8);
        end
        check("wrap_off9", offset, 9);
        dly = 7;
        for (int i = 0; i < T; i++) send_tok(2'b10);
        check("wrap_off0", offset, 0);
        for (int i = 0; i < 7 * T + RUN + 2; i++) send_tok(2'b10);
        check("wrap_locked", locked, 1);
        check("wrap_offset", offset, 7);
        chk_en = 1'b1;
        send_pixels();
        do_reset();

        // 300 lock losses saturate the relock counter
        for (int it = 1; it <= 300; it++) begin
            for (int i = 0; i < 20; i++) send_tok(2'(it));
            if (it == 1 || it == 300) check("sat_locked", locked, 1);
            for (int m = 0; m < T + 2; m++) send_px(8'(m + it), 1'(m % 2));
            dly = (dly + 1) % 10;
            if (it == 1)   check("sat_cnt1", relock_count, 1);
            if (it == 254) check("sat_cnt254", relock_count, 254);
            if (it == 255) check("sat_cnt255", relock_count, 255);
        end
        check("sat_cnt300", relock_count, 255);
        check("sat_offset", offset, dly);
        check("sat_unlocked", locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
